// File: rtl/mode_select_ctrl_if.sv
// Bundle of the menu controller's board-side and video/game-side signals.
// master: the environment (buttons, game core, scan counters).
// slave : the mode_select_ctrl block itself.
interface mode_select_ctrl_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_select;
   logic       game_over;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       in_cursor;
   logic       in_menu;
   logic       start_pulse;
   logic       game_mode;

   modport master (
      output btn_up, btn_down, btn_select, game_over, pixel_x, pixel_y,
      input  in_cursor, in_menu, start_pulse, game_mode
   );

   modport slave (
      input  btn_up, btn_down, btn_select, game_over, pixel_x, pixel_y,
      output in_cursor, in_menu, start_pulse, game_mode
   );
endinterface

// File: rtl/mode_select_ctrl.sv
// Startup menu input controller: synchronises and debounces the three player
// buttons, steps a selection cursor between "1 PLAYER" and "2 PLAYERS",
// latches the chosen game mode and renders the cursor as a registered mask.
// Optional build macro: MENU_WRAP_EN (cursor wraps instead of saturating).
module mode_select_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CURSOR_X        = 200,
   parameter int SP_Y            = 258,
   parameter int MP_Y            = 301,
   parameter int CURSOR_SIZE     = 24
) (
   input  logic              clk_0,
   input  logic              rst,
   mode_select_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_MENU    = 2'd0,
      ST_START   = 2'd1,
      ST_PLAY    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   // Button index map: 0 = up, 1 = down, 2 = select.
   localparam int          BTN_UP  = 0;
   localparam int          BTN_DN  = 1;
   localparam int          BTN_SEL = 2;

   localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);

   // Cursor geometry widened to 11 bits so the upper bounds never wrap.
   localparam logic [10:0] CX_LO  = 11'(CURSOR_X);
   localparam logic [10:0] CX_HI  = 11'(CURSOR_X + CURSOR_SIZE);
   localparam logic [10:0] SP_Y11 = 11'(SP_Y);
   localparam logic [10:0] MP_Y11 = 11'(MP_Y);
   localparam logic [10:0] SIZE11 = 11'(CURSOR_SIZE);

   logic [2:0]       btn_raw_s;
   logic [2:0]       sync1_q;
   logic [2:0]       sync2_q;
   logic [2:0]       stable_q;
   logic [2:0]       stable_d;
   logic [2:0]       stable_dly_q;
   logic [2:0]       press_q;
   logic [2:0][19:0] cnt_q;
   logic [2:0][19:0] cnt_d;

   state_t           state_q;
   state_t           state_d;
   logic             sel_q;
   logic             sel_d;
   logic             game_mode_q;
   logic             game_mode_d;
   logic             in_menu_q;
   logic             start_pulse_q;
   logic             in_cursor_q;
   logic             cursor_hit_s;
   logic [10:0]      cy_s;
   logic [10:0]      px_s;
   logic [10:0]      py_s;

   assign btn_raw_s = {bus.btn_select, bus.btn_down, bus.btn_up};

   // Debounce next state: count while the synchronised level disagrees with
   // the accepted level, accept it on terminal count, clear on agreement.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               stable_d[i] = sync2_q[i];
               cnt_d[i]    = 20'd0;
            end else begin
               cnt_d[i]    = cnt_q[i] + 20'd1;
            end
         end else begin
            cnt_d[i] = 20'd0;
         end
      end
   end

   // Button path registers: 2-flop synchroniser, debouncer state and a
   // one-cycle press pulse on each rising edge of the accepted level.
   always_ff @(posedge clk_0 or negedge rst) begin
      if (!rst) begin
         sync1_q      <= 3'b000;
         sync2_q      <= 3'b000;
         stable_q     <= 3'b000;
         stable_dly_q <= 3'b000;
         press_q      <= 3'b000;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= btn_raw_s;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         press_q      <= stable_q & ~stable_dly_q;
         cnt_q        <= cnt_d;
      end
   end

   // Menu FSM next state, cursor selection and mode latch.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      game_mode_d = game_mode_q;
      case (state_q)
         ST_MENU: begin
            // Select has priority so a coincident move cannot alter the mode.
            if (press_q[BTN_SEL]) begin
               game_mode_d = sel_q;
               state_d     = ST_START;
            end else if (press_q[BTN_UP] && !press_q[BTN_DN]) begin
`ifdef MENU_WRAP_EN
               sel_d = ~sel_q;
`else
               sel_d = 1'b0;
`endif
            end else if (press_q[BTN_DN] && !press_q[BTN_UP]) begin
`ifdef MENU_WRAP_EN
               sel_d = ~sel_q;
`else
               sel_d = 1'b1;
`endif
            end else begin
               sel_d = sel_q;
            end
         end
         ST_START: begin
            state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (bus.game_over) begin
               state_d = ST_RELEASE;
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_RELEASE: begin
            // Wait for every button to be released so a held key cannot
            // act on the menu the moment it reappears.
            if (stable_q == 3'b000) begin
               state_d = ST_MENU;
               sel_d   = game_mode_q;
            end else begin
               state_d = ST_RELEASE;
            end
         end
         default: begin
            state_d = ST_MENU;
         end
      endcase
   end

   // Cursor hit test against the current scan position.
   always_comb begin
      cursor_hit_s = 1'b0;
      px_s         = {1'b0, bus.pixel_x};
      py_s         = {1'b0, bus.pixel_y};
      if (sel_q) begin
         cy_s = MP_Y11;
      end else begin
         cy_s = SP_Y11;
      end
      if ((state_q == ST_MENU) &&
          (px_s >= CX_LO) && (px_s < CX_HI) &&
          (py_s >= cy_s) && (py_s < (cy_s + SIZE11))) begin
         cursor_hit_s = 1'b1;
      end else begin
         cursor_hit_s = 1'b0;
      end
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk_0 or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_MENU;
         sel_q         <= 1'b0;
         game_mode_q   <= 1'b0;
         in_menu_q     <= 1'b1;
         start_pulse_q <= 1'b0;
         in_cursor_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         game_mode_q   <= game_mode_d;
         in_menu_q     <= (state_d == ST_MENU);
         start_pulse_q <= (state_d == ST_START);
         in_cursor_q   <= cursor_hit_s;
      end
   end

   assign bus.in_menu     = in_menu_q;
   assign bus.start_pulse = start_pulse_q;
   assign bus.game_mode   = game_mode_q;
   assign bus.in_cursor   = in_cursor_q;

endmodule

// File: tb/tb_mode_select_ctrl.sv
// Self-checking bench for mode_select_ctrl with a short debounce window.
// Cursor and start-pulse expectations are queued when stimulus is applied
// and compared by monitor processes when the DUT output appears.
module tb_mode_select_ctrl;

   localparam int DEB = 4;
`ifdef MENU_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic clk_0 = 1'b0;
   logic rst   = 1'b0;

   mode_select_ctrl_if bus ();

   mode_select_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .CURSOR_X        (200),
      .SP_Y            (258),
      .MP_Y            (301),
      .CURSOR_SIZE     (24)
   ) dut (
      .clk_0 (clk_0),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clk_0 = ~clk_0;

   int n_checks = 0;
   int n_fail   = 0;
   bit cur_q[$];
   bit start_q[$];
   bit m_sel;
   bit m_menu;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference cursor mask from the menu geometry.
   function automatic bit cursor_exp(input int x, input int y, input bit menu, input bit sel);
      int cy;
      cy = sel ? 301 : 258;
      return menu && (x >= 200) && (x < 224) && (y >= cy) && (y < cy + 24);
   endfunction

   task automatic tick();
      @(posedge clk_0);
      #1;
   endtask

   task automatic probe(input int x, input int y);
      @(posedge clk_0);
      #1;
      bus.pixel_x = 10'(x);
      bus.pixel_y = 10'(y);
      cur_q.push_back(cursor_exp(x, y, m_menu, m_sel));
   endtask

   task automatic press_btns(input bit up, input bit dn, input bit sel);
      bus.btn_up     = up;
      bus.btn_down   = dn;
      bus.btn_select = sel;
      repeat (10) tick();
      bus.btn_up     = 1'b0;
      bus.btn_down   = 1'b0;
      bus.btn_select = 1'b0;
      repeat (12) tick();
   endtask

   // Cursor monitor: a pixel presented before an edge is judged after it.
   initial begin
      int n_due;
      bit e;
      forever begin
         @(posedge clk_0);
         n_due = cur_q.size();
         @(negedge clk_0);
         if (n_due > 0) begin
            e = cur_q.pop_front();
            check_val("cursor", int'(bus.in_cursor), int'(e));
         end
      end
   end

   // Start monitor: every start cycle must match one queued expectation.
   initial begin
      bit e;
      forever begin
         @(negedge clk_0);
         if (bus.start_pulse) begin
            if (start_q.size() == 0) begin
               check_val("spurious_start", 1, 0);
            end else begin
               e = start_q.pop_front();
               check_val("start_mode", int'(bus.game_mode), int'(e));
               check_val("start_in_menu", int'(bus.in_menu), 0);
            end
         end
      end
   end

   initial begin
      int px[8] = '{210, 210, 199, 224, 200, 223, 210, 210};
      int py[8] = '{270, 310, 270, 270, 258, 281, 282, 257};
      bus.btn_up     = 1'b0;
      bus.btn_down   = 1'b0;
      bus.btn_select = 1'b0;
      bus.game_over  = 1'b0;
      bus.pixel_x    = 10'd0;
      bus.pixel_y    = 10'd0;
      m_sel  = 1'b0;
      m_menu = 1'b1;

      // Reset values
      repeat (3) tick();
      check_val("rst_in_menu", int'(bus.in_menu), 1);
      check_val("rst_game_mode", int'(bus.game_mode), 0);
      check_val("rst_start", int'(bus.start_pulse), 0);
      check_val("rst_cursor", int'(bus.in_cursor), 0);
      rst = 1'b1;
      tick();

      // Cursor geometry around the "1 PLAYER" line
      for (int i = 0; i < 8; i++) probe(px[i], py[i]);

      // game_over is ignored in the menu
      tick();
      bus.game_over = 1'b1;
      tick();
      bus.game_over = 1'b0;
      tick();
      check_val("menu_ignores_game_over", int'(bus.in_menu), 1);

      // Glitches of 3 cycles are rejected
      bus.btn_down = 1'b1;
      repeat (3) tick();
      bus.btn_down = 1'b0;
      repeat (12) tick();
      probe(210, 270);
      probe(210, 310);
      bus.btn_up = 1'b1;
      repeat (3) tick();
      bus.btn_up = 1'b0;
      repeat (12) tick();
      probe(210, 270);

      // Up and down together are both ignored
      press_btns(1'b1, 1'b1, 1'b0);
      probe(210, 270);
      probe(210, 310);

      // Select with down: select wins, mode takes pre-move selection
      start_q.push_back(1'b0);
      press_btns(1'b0, 1'b1, 1'b1);
      m_menu = 1'b0;
      check_val("play_in_menu", int'(bus.in_menu), 0);
      check_val("play_game_mode", int'(bus.game_mode), 0);
      check_val("start_seen_1", start_q.size(), 0);
      probe(210, 270);

      // Return path with select held across game_over
      bus.btn_select = 1'b1;
      repeat (12) tick();
      bus.game_over = 1'b1;
      tick();
      bus.game_over = 1'b0;
      repeat (4) tick();
      check_val("release_hold_a", int'(bus.in_menu), 0);
      repeat (10) tick();
      check_val("release_hold_b", int'(bus.in_menu), 0);
      bus.btn_select = 1'b0;
      repeat (3) tick();
      check_val("release_debounce", int'(bus.in_menu), 0);
      repeat (10) tick();
      check_val("release_done", int'(bus.in_menu), 1);
      m_menu = 1'b1;
      m_sel  = 1'b0;
      probe(210, 270);

      // Down moves the cursor to the "2 PLAYERS" line
      press_btns(1'b0, 1'b1, 1'b0);
      m_sel = 1'b1;
      probe(210, 301);
      probe(210, 324);
      probe(210, 325);
      probe(210, 300);
      probe(210, 270);

      // Select confirms two-player mode
      start_q.push_back(1'b1);
      press_btns(1'b0, 1'b0, 1'b1);
      m_menu = 1'b0;
      check_val("start_seen_2", start_q.size(), 0);
      check_val("mp_in_menu", int'(bus.in_menu), 0);
      check_val("mp_game_mode", int'(bus.game_mode), 1);

      // Presses during play do not touch the mode
      press_btns(1'b1, 1'b0, 1'b0);
      check_val("play_hold_mode", int'(bus.game_mode), 1);
      check_val("play_hold_state", int'(bus.in_menu), 0);

      // Reset mid-play returns to the menu without a clock edge
      @(posedge clk_0);
      #2;
      rst = 1'b0;
      #1;
      check_val("async_rst_menu", int'(bus.in_menu), 1);
      check_val("async_rst_mode", int'(bus.game_mode), 0);
      tick();
      rst = 1'b1;
      m_sel  = 1'b0;
      m_menu = 1'b1;
      tick();

      // Up from the top line: wraps only in the wrap build
      press_btns(1'b1, 1'b0, 1'b0);
      m_sel = WRAP ? 1'b1 : 1'b0;
      probe(210, 270);
      probe(210, 310);

      repeat (3) tick();
      check_val("cursor_queue_drained", cur_q.size(), 0);
      check_val("start_queue_drained", start_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
